// File: rtl/mult_seq_controller_pkg.sv
// mult_seq_controller_pkg: shared state encoding and width constants for the sequential multiplier.
package mult_seq_controller_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int PROD_W = 2 * WIDTH_DEF;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/mult_seq_controller_if.sv
// mult_seq_controller_if: start/done handshake, operands and held product.
interface mult_seq_controller_if import mult_seq_controller_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
    logic               i_start;
    logic [WIDTH-1:0]   i_op_a;
    logic [WIDTH-1:0]   i_op_b;
    logic               o_ready;
    logic               o_busy;
    logic               o_done;
    logic [2*WIDTH-1:0] o_result;
    modport master (output i_start, i_op_a, i_op_b, input o_ready, o_busy, o_done, o_result);
    modport slave (input i_start, i_op_a, i_op_b, output o_ready, o_busy, o_done, o_result);
endinterface

// File: rtl/mult_seq_controller_datapath.sv
// mult_step_datapath: one shift-and-add step built from a shared shifter and ripple-carry adder.
module logical_left_shift_32_bit #(parameter int W = 32) (
    input  logic [W-1:0]         i_data,
    input  logic [$clog2(W)-1:0] i_shamt,
    output logic [W-1:0]         o_data
);
    assign o_data = i_data << i_shamt;
endmodule

module ripple_carry_32_bit #(parameter int W = 32) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum
);
    logic [W-1:0] w_c;
    assign w_c[0] = i_cin;
    for (genvar g = 0; g < W; g++) begin : g_fa
        assign o_sum[g] = i_a[g] ^ i_b[g] ^ w_c[g];
        if (g < W - 1) begin : g_c
            assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
        end
    end
endmodule

module mult_step_datapath import mult_seq_controller_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input  logic [2*WIDTH-1:0]       i_acc,
    input  logic [2*WIDTH-1:0]       i_a,
    input  logic [$clog2(WIDTH)-1:0] i_i,
    input  logic                     i_bit,
    input  logic                     i_last,
    output logic [2*WIDTH-1:0]       o_next_acc
);
    localparam int PW = 2 * WIDTH;
    localparam int PSW = $clog2(PW);
    logic [PW-1:0] w_sh, w_addend, w_sum;
    logic [PSW-1:0] w_shamt;
    assign w_shamt = PSW'(i_i);
    logical_left_shift_32_bit #(.W(PW)) u_shl (.i_data(i_a), .i_shamt(w_shamt), .o_data(w_sh));
    // The sign bit carries negative weight, so the last step adds ~sh + 1.
    assign w_addend = i_last ? ~w_sh : w_sh;
    ripple_carry_32_bit #(.W(PW)) u_add (.i_a(i_acc), .i_b(w_addend), .i_cin(i_last), .o_sum(w_sum));
    assign o_next_acc = i_bit ? w_sum : i_acc;
endmodule

// File: rtl/mult_seq_controller.sv
// mult_seq_controller: signed multi-cycle shift-and-add multiplier, one multiplier bit per clock.
module mult_seq_controller import mult_seq_controller_pkg::*; #(
    parameter int WIDTH      = WIDTH_DEF,
    parameter bit EARLY_EXIT = 1'b0
) (
    input logic clk,
    input logic rst,
    mult_seq_controller_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH);
    state_t r_state, w_next;
    logic [SW-1:0] r_step;
    logic [PW-1:0] r_a, r_acc, r_result, w_next_acc;
    logic [WIDTH-1:0] r_b;
    logic [SW:0] w_step_inc;
    logic w_accept, w_last, w_finish;

    assign w_accept = (r_state != S_RUN) && bus.i_start;
    assign w_last = r_step == SW'(WIDTH - 1);
    assign w_step_inc = {1'b0, r_step} + 1'b1;
    assign w_finish = w_last || (EARLY_EXIT && ((r_b >> w_step_inc) == '0));

    mult_step_datapath #(.WIDTH(WIDTH)) u_step (
        .i_acc(r_acc), .i_a(r_a), .i_i(r_step), .i_bit(r_b[r_step]), .i_last(w_last),
        .o_next_acc(w_next_acc)
    );

    always_comb begin
        w_next = (r_state == S_RUN) ? (w_finish ? S_DONE : S_RUN) : (w_accept ? S_RUN : S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_acc <= '0;
            r_step <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a <= {{WIDTH{bus.i_op_a[WIDTH-1]}}, bus.i_op_a};
            r_b <= bus.i_op_b;
            r_acc <= '0;
            r_step <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_next_acc;
            r_step <= r_step + 1'b1;
            if (w_finish) r_result <= w_next_acc;
        end
    end

    assign bus.o_ready = r_state != S_RUN;
    assign bus.o_busy = r_state == S_RUN;
    assign bus.o_done = r_state == S_DONE;
    assign bus.o_result = r_result;
endmodule
